// File: rtl/bv_urem_pkg.sv
// Shared types, reset constants and the signed less-than helper for the bv_urem_slt_seq datapath.
package bv_urem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Widest operand the slt_f helper handles.
    localparam int unsigned MAX_W = 64;

    localparam state_t RST_STATE     = IDLE;
    localparam logic   RST_IN_READY  = 1'b1;
    localparam logic   RST_OUT_VALID = 1'b0;
    localparam logic   RST_OUT_SLT   = 1'b0;
    localparam logic   RST_OUT_DIVZ  = 1'b0;

    // Signed x < y over the low w bits: shifting the sign bit into the MSB
    // lets a single full-width signed compare serve every width.
    function automatic logic slt_f(input logic [MAX_W-1:0] x,
                                   input logic [MAX_W-1:0] y,
                                   input int unsigned      w);
        logic [MAX_W-1:0] xs;
        logic [MAX_W-1:0] ys;
        xs = x << (MAX_W - w);
        ys = y << (MAX_W - w);
        return $signed(xs) < $signed(ys);
    endfunction

endpackage

// File: rtl/bv_urem_slt_seq_cmp.sv
// Combinational two's-complement less-than over W bits (module bv_slt_cmp).
module bv_slt_cmp
    import bv_urem_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    output logic         lt_o
);

    always_comb begin
        lt_o = slt_f(MAX_W'(x_i), MAX_W'(y_i), W);
    end

endmodule

// File: rtl/bv_urem_slt_seq.sv
// Serial restoring unsigned remainder (SMT-LIB bvurem, b==0 -> a) plus signed r <s t predicate.
// Optional build macro BV_UREM_EARLY_EXIT_EN: a <u b with b!=0 completes in one edge.
module bv_urem_slt_seq
    import bv_urem_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [W-1:0] in_t,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_rem,
    output logic         out_slt,
    output logic         out_divz
);

    localparam int unsigned CW = $clog2(W + 1);

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   a_sh_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   t_q;
    logic [W:0]     r_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic [W-1:0]   out_rem_q;
    logic           out_slt_q;
    logic           out_divz_q;

    logic [W:0]     r_shift;
    logic [W:0]     r_d;
    logic [W-1:0]   cmp_x;
    logic [W-1:0]   cmp_y;
    logic           cmp_lt;
    logic           accept;

    // The dividend is shifted out MSB-first instead of indexed by the counter,
    // which yields the same bit sequence a[counter-1] without a variable select.
    always_comb begin
        r_shift = {r_q[W-1:0], a_sh_q[W-1]};
        r_d     = r_shift;
        if (r_shift >= {1'b0, b_q}) begin
            r_d = r_shift - {1'b0, b_q};
        end
    end

    // In IDLE the compare sees the raw operands (divide-by-zero / early exit);
    // in BUSY it sees the remainder being produced this cycle.
    always_comb begin
        cmp_x = r_d[W-1:0];
        cmp_y = t_q;
        if (state_q == IDLE) begin
            cmp_x = in_a;
            cmp_y = in_t;
        end
    end

    bv_slt_cmp #(
        .W (W)
    ) u_cmp (
        .x_i  (cmp_x),
        .y_i  (cmp_y),
        .lt_o (cmp_lt)
    );

    assign accept = in_valid && in_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RST_STATE;
            cnt_q       <= '0;
            a_sh_q      <= '0;
            b_q         <= '0;
            t_q         <= '0;
            r_q         <= '0;
            in_ready_q  <= RST_IN_READY;
            out_valid_q <= RST_OUT_VALID;
            out_rem_q   <= '0;
            out_slt_q   <= RST_OUT_SLT;
            out_divz_q  <= RST_OUT_DIVZ;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_sh_q     <= in_a;
                        b_q        <= in_b;
                        t_q        <= in_t;
                        r_q        <= '0;
                        cnt_q      <= CW'(W);
                        in_ready_q <= 1'b0;
                        if (in_b == '0) begin
                            state_q     <= DONE;
                            out_rem_q   <= in_a;
                            out_slt_q   <= cmp_lt;
                            out_divz_q  <= 1'b1;
                            out_valid_q <= 1'b1;
`ifdef BV_UREM_EARLY_EXIT_EN
                        end else if (in_a < in_b) begin
                            state_q     <= DONE;
                            out_rem_q   <= in_a;
                            out_slt_q   <= cmp_lt;
                            out_divz_q  <= 1'b0;
                            out_valid_q <= 1'b1;
`endif
                        end else begin
                            state_q    <= BUSY;
                            out_divz_q <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    r_q    <= r_d;
                    a_sh_q <= a_sh_q << 1;
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q     <= DONE;
                        out_rem_q   <= r_d[W-1:0];
                        out_slt_q   <= cmp_lt;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_rem   = out_rem_q;
    assign out_slt   = out_slt_q;
    assign out_divz  = out_divz_q;

endmodule
